ram_sync_clr: RTL and testbench

RAM_SYNC_CLR -- requirements
Module: ram_sync_clr

---
 rtl/ram_sync_clr.sv | 103 ++++++++++
 tb/tb_ram_sync_clr.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM with a registered read port and a built-in
// full-memory clear sequencer that runs after reset and on request.
module ram_sync_clr #(
  parameter int unsigned ADDR_SIZE   = 10,
  parameter int unsigned WORD_SIZE   = 8,
  parameter int unsigned MEMORY_SIZE = 1024,
  parameter int unsigned WR_THROUGH  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs,
  input  logic                 wr,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 clr,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 rd_valid,
  output logic                 busy
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEMORY_SIZE - 1);
  localparam logic [ADDR_SIZE:0]   MEM_LIMIT = (ADDR_SIZE + 1)'(MEMORY_SIZE);
  localparam bit                   WT_EN     = (WR_THROUGH != 0);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e                 state_q;
  logic [ADDR_SIZE-1:0]   clr_cnt_q;
  logic [WORD_SIZE-1:0]   data_out_q;
  logic                   rd_valid_q;
  logic [WORD_SIZE-1:0]   mem_q [MEMORY_SIZE];

  logic                   in_range_c;
  logic                   user_rd_c;
  logic                   user_wr_c;
  logic                   mem_we_c;
  logic [ADDR_SIZE-1:0]   mem_waddr_c;
  logic [WORD_SIZE-1:0]   mem_wdata_c;
  logic [WORD_SIZE-1:0]   rd_word_c;

  // Access qualification: user traffic only in IDLE, and never on a clr edge.
  always_comb begin
    in_range_c  = ({1'b0, addr} < MEM_LIMIT);
    user_rd_c   = 1'b0;
    user_wr_c   = 1'b0;
    if ((state_q == ST_IDLE) && !clr && cs) begin
      user_rd_c = !wr;
      user_wr_c = wr;
    end
    mem_we_c    = (state_q == ST_CLEAR) || (user_wr_c && in_range_c);
    mem_waddr_c = (state_q == ST_CLEAR) ? clr_cnt_q : addr;
    mem_wdata_c = (state_q == ST_CLEAR) ? '0 : data_in;
    rd_word_c   = in_range_c ? mem_q[addr] : '0;
  end

  // Storage array; reset edges never write it.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  // Clear sequencer and registered read port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_SIZE'(1);
          if (clr_cnt_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (clr) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
          end else if (user_rd_c) begin
            data_out_q <= rd_word_c;
            rd_valid_q <= 1'b1;
          end else if (user_wr_c && WT_EN) begin
            data_out_q <= data_in;
            rd_valid_q <= 1'b1;
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_sync_clr.sv
// Bench for ram_sync_clr: a default instance and a 1000-word write-through
// instance share stimulus and are tracked by a per-edge reference model.
module tb_ram_sync_clr;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n, cs, wr, clr;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] dout_a, dout_b;
  logic          valid_a, valid_b, busy_a, busy_b;

  always #5 clk = ~clk;

  ram_sync_clr #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .MEMORY_SIZE(1024), .WR_THROUGH(0)) u_a (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .addr(addr), .data_in(data_in),
    .clr(clr), .data_out(dout_a), .rd_valid(valid_a), .busy(busy_a)
  );

  ram_sync_clr #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .MEMORY_SIZE(1000), .WR_THROUGH(1)) u_b (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .addr(addr), .data_in(data_in),
    .clr(clr), .data_out(dout_b), .rd_valid(valid_b), .busy(busy_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: memory contents plus remaining busy cycles per instance.
  int unsigned msz [2] = '{1024, 1000};
  bit          mwt [2] = '{1'b0, 1'b1};
  logic [7:0]  m_mem [2][1024];
  int          m_busy [2];
  logic [7:0]  m_dout [2];
  bit          m_valid [2];
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n || (m_busy[i] == 0 && clr)) begin
        if (!rst_n) m_dout[i] = 8'h00;
        m_busy[i]  = int'(msz[i]);
        m_valid[i] = 1'b0;
        for (int j = 0; j < 1024; j++) m_mem[i][j] = 8'h00;
      end else if (m_busy[i] > 0) begin
        m_busy[i]--;
        m_valid[i] = 1'b0;
      end else if (cs && wr) begin
        if (addr < msz[i]) m_mem[i][addr] = data_in;
        if (mwt[i]) begin
          m_dout[i]  = data_in;
          m_valid[i] = 1'b1;
        end else begin
          m_valid[i] = 1'b0;
        end
      end else if (cs) begin
        m_dout[i]  = (addr < msz[i]) ? m_mem[i][addr] : 8'h00;
        m_valid[i] = 1'b1;
      end else begin
        m_valid[i] = 1'b0;
      end
    end
    if (!rst_n) model_on = 1'b1;
    #1;
    if (model_on) begin
      chk("model busy_a",     busy_a,  m_busy[0] > 0);
      chk("model rd_valid_a", valid_a, m_valid[0]);
      chk("model data_out_a", dout_a,  m_dout[0]);
      chk("model busy_b",     busy_b,  m_busy[1] > 0);
      chk("model rd_valid_b", valid_b, m_valid[1]);
      chk("model data_out_b", dout_b,  m_dout[1]);
    end
  end

  typedef struct {
    logic       cs;
    logic       wr;
    logic [9:0] addr;
    logic [7:0] din;
    logic       exp_valid;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cs = 1'b0; wr = 1'b0; clr = 1'b0; addr = '0; data_in = '0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy_a && n < 5000) begin
      n++;
      tick();
    end
  endtask

  int n, bad_valid, bad_hold;
  int ra [3] = '{5, 200, 1023};
  int re [3] = '{10, 144, 254};

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 10'd0,    8'h00, 1'b1, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 10'd511,  8'h00, 1'b1, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 10'd1023, 8'h00, 1'b1, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 10'd7,    8'hAA, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 10'd7,    8'h00, 1'b1, 8'hAA};
    vecs[5]  = '{1'b0, 1'b0, 10'd7,    8'h00, 1'b0, 8'hAA};
    vecs[6]  = '{1'b1, 1'b1, 10'd1023, 8'h5A, 1'b0, 8'hAA};
    vecs[7]  = '{1'b1, 1'b0, 10'd1023, 8'h00, 1'b1, 8'h5A};
    vecs[8]  = '{1'b0, 1'b1, 10'd12,   8'h77, 1'b0, 8'h5A};
    vecs[9]  = '{1'b1, 1'b0, 10'd12,   8'h00, 1'b1, 8'h00};
    vecs[10] = '{1'b1, 1'b1, 10'd12,   8'hC3, 1'b0, 8'h00};
    vecs[11] = '{1'b1, 1'b0, 10'd12,   8'h00, 1'b1, 8'hC3};
    vecs[12] = '{1'b1, 1'b0, 10'd7,    8'h00, 1'b1, 8'hAA};

    rst_n = 1'b0;
    idle_inputs();
    repeat (3) tick();
    chk("reset busy",     busy_a,  1);
    chk("reset rd_valid", valid_a, 0);
    chk("reset data_out", dout_a,  0);
    chk("reset busy_b",   busy_b,  1);

    rst_n = 1'b1;
    count_busy(n);
    chk("power-up busy cycles", n, 1024);

    for (int i = 0; i < 13; i++) begin
      cs = vecs[i].cs; wr = vecs[i].wr; addr = vecs[i].addr; data_in = vecs[i].din;
      tick();
      chk($sformatf("vec%0d rd_valid", i), valid_a, vecs[i].exp_valid);
      chk($sformatf("vec%0d data_out", i), dout_a,  vecs[i].exp_dout);
    end
    idle_inputs();
    tick();

    // Fill pattern then spot reads with single-cycle rd_valid.
    cs = 1'b1; wr = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      addr = AW'(k);
      data_in = DW'(2 * k);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      cs = 1'b1; wr = 1'b0; addr = AW'(ra[i]);
      tick();
      chk($sformatf("pattern rd_valid @%0d", ra[i]), valid_a, 1);
      chk($sformatf("pattern data_out @%0d", ra[i]), dout_a,  re[i]);
      cs = 1'b0;
      tick();
      chk($sformatf("pattern pulse end @%0d", ra[i]), valid_a, 0);
    end

    // Clear request with a read held on the bus throughout.
    cs = 1'b1; wr = 1'b1; addr = 10'd7; data_in = 8'hAA;
    tick();
    wr = 1'b0;
    tick();
    chk("pre-clear read", dout_a, 8'hAA);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bad_valid = 0; bad_hold = 0; n = 0;
    while (busy_a && n < 5000) begin
      if (valid_a !== 1'b0) bad_valid++;
      if (dout_a !== 8'hAA) bad_hold++;
      n++;
      tick();
    end
    chk("clr busy cycles", n, 1024);
    chk("rd_valid during busy", bad_valid, 0);
    chk("data_out hold during busy", bad_hold, 0);
    tick();
    chk("post-clear read valid", valid_a, 1);
    chk("post-clear read data",  dout_a,  0);

    // Out-of-range and write-through on the 1000-word instance.
    cs = 1'b1; wr = 1'b1; addr = 10'd1010; data_in = 8'h55;
    tick();
    wr = 1'b0;
    tick();
    chk("oor read valid_b", valid_b, 1);
    chk("oor read data_b",  dout_b,  0);
    chk("in-range read data_a", dout_a, 8'h55);
    wr = 1'b1; addr = 10'd9; data_in = 8'h3C;
    tick();
    chk("write-through data_b",  dout_b,  8'h3C);
    chk("write-through valid_b", valid_b, 1);
    chk("no write-through valid_a", valid_a, 0);
    chk("no write-through data_a",  dout_a,  8'h55);
    idle_inputs();

    // Reset in the middle of a clear restarts it from zero.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n = 0;
    while (busy_a && n < 300) begin
      n++;
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("mid-clear reset data_out", dout_a, 0);
    rst_n = 1'b1;
    count_busy(n);
    chk("restarted busy cycles", n, 1024);
    chk("restarted data_out", dout_a, 0);

    for (int c = 0; c < 4000; c++) begin
      rst_n   = ($urandom % 5000) != 0;
      clr     = ($urandom % 3000) == 0;
      cs      = ($urandom % 4) != 0;
      wr      = $urandom % 2;
      addr    = ($urandom % 2) ? AW'($urandom % 16) : AW'($urandom % 1024);
      data_in = DW'($urandom);
      tick();
    end
    rst_n = 1'b1;
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
